// File: rtl/operand_entry_pkg.sv
// operand_entry_pkg: key codes and FSM state type shared by the operand entry front end
package operand_entry_pkg;
  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_SIGN  = 4'hB;
  localparam logic [3:0] KEY_ENTER = 4'hC;
  typedef enum logic {ENTRY, HANDOFF} entry_state_t;
endpackage

// File: rtl/key_edge_detect.sv
// key_edge_detect: turns the scanner's key-held level into a single-cycle key event
module key_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level_in,
  output logic pulse_out
);
  logic prev_q;
  // remember last cycle's level so a held key fires only once
  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b0;
    else prev_q <= level_in;
  end
  assign pulse_out = level_in & ~prev_q;
endmodule

// File: rtl/operand_entry_ctrl.sv
// operand_entry_ctrl: keypad decimal operand entry with valid/ready handoff; OPERAND_ENTRY_SAT_EN saturates overflowing digits
module operand_entry_ctrl
  import operand_entry_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int NUM_OPS    = 2,
  parameter int MAX_DIGITS = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         key_valid,
  input  logic [3:0]                   key_code,
  input  logic                         ops_ready,
  output logic                         ops_valid,
  output logic [NUM_OPS*WIDTH-1:0]     operands,
  output logic [WIDTH-1:0]             entry_value,
  output logic [$clog2(NUM_OPS):0]     op_idx,
  output logic                         err
);
  localparam int IW = $clog2(NUM_OPS) + 1;
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_OPS - 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITS);
  localparam logic [WIDTH+3:0] POS_LIM = {5'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH+3:0] NEG_LIM = {4'b0, 1'b1, {(WIDTH-1){1'b0}}};

  entry_state_t state_q, state_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic sign_q, sign_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [NUM_OPS*WIDTH-1:0] ops_q, ops_d;
  logic valid_q, valid_d;
  logic err_q, err_d;
  logic ev;
  logic [WIDTH+3:0] ext, prod, limit;

  key_edge_detect u_edge (.clk(clk), .rst(rst), .level_in(key_valid), .pulse_out(ev));

  assign ext = {4'b0, mag_q};
  assign prod = (ext << 3) + (ext << 1) + {{WIDTH{1'b0}}, key_code};
  assign limit = sign_q ? NEG_LIM : POS_LIM;
  assign entry_value = sign_q ? -mag_q : mag_q;
  assign ops_valid = valid_q;
  assign operands = ops_q;
  assign op_idx = idx_q;
  assign err = err_q;

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ENTRY;
      mag_q <= '0;
      sign_q <= 1'b0;
      cnt_q <= '0;
      idx_q <= '0;
      ops_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q <= mag_d;
      sign_q <= sign_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      ops_q <= ops_d;
      valid_q <= valid_d;
      err_q <= err_d;
    end
  end

  // key decode, entry accumulation and handoff sequencing
  always_comb begin
    state_d = state_q;
    mag_d = mag_q;
    sign_d = sign_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    ops_d = ops_q;
    valid_d = valid_q;
    err_d = ev && key_code > KEY_ENTER;
    if (ev && key_code == KEY_CLEAR) begin
      state_d = ENTRY;
      mag_d = '0;
      sign_d = 1'b0;
      cnt_d = '0;
      idx_d = '0;
      ops_d = '0;
      valid_d = 1'b0;
    end else if (state_q == HANDOFF) begin
      if (valid_q && ops_ready) begin
        valid_d = 1'b0;
        idx_d = '0;
        state_d = ENTRY;
      end
    end else if (ev && key_code <= 4'd9) begin
      if (cnt_q == MAX_CNT) err_d = 1'b1;
      else if (prod > limit) begin
        err_d = 1'b1;
`ifdef OPERAND_ENTRY_SAT_EN
        mag_d = limit[WIDTH-1:0];
        cnt_d = cnt_q + 1'b1;
`endif
      end else begin
        mag_d = prod[WIDTH-1:0];
        cnt_d = cnt_q + 1'b1;
      end
    end else if (ev && key_code == KEY_SIGN) begin
      if (sign_q && ext > POS_LIM) err_d = 1'b1;
      else sign_d = ~sign_q;
    end else if (ev && key_code == KEY_ENTER) begin
      if (cnt_q == '0) err_d = 1'b1;
      else begin
        ops_d[idx_q*WIDTH +: WIDTH] = entry_value;
        mag_d = '0;
        sign_d = 1'b0;
        cnt_d = '0;
        if (idx_q == LAST_IDX) begin
          valid_d = 1'b1;
          state_d = HANDOFF;
        end else idx_d = idx_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_operand_entry_ctrl.sv
// tb_operand_entry_ctrl: directed scoreboard bench for operand_entry_ctrl (WIDTH=8, NUM_OPS=2, MAX_DIGITS=3)
module tb_operand_entry_ctrl;
  logic clk = 1'b0, rst = 1'b1, key_valid = 1'b0, ops_ready = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic ops_valid, err;
  logic [15:0] operands;
  logic [7:0] entry_value;
  logic [1:0] op_idx;
  int tests = 0, fails = 0;

  typedef struct { string tag; int sel; logic [15:0] exp; } exp_t;
  exp_t sb[$];

  operand_entry_ctrl #(.WIDTH(8), .NUM_OPS(2), .MAX_DIGITS(3)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .ops_ready(ops_ready),
    .ops_valid(ops_valid), .operands(operands), .entry_value(entry_value), .op_idx(op_idx), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] observe(input int s);
    case (s)
      0: observe = {8'h0, entry_value};
      1: observe = {15'h0, err};
      2: observe = {15'h0, ops_valid};
      3: observe = operands;
      default: observe = {14'h0, op_idx};
    endcase
  endfunction

  task automatic push(input string tag, input int s, input logic [15:0] e);
    exp_t x;
    x.tag = tag; x.sel = s; x.exp = e;
    sb.push_back(x);
  endtask

  task automatic drain();
    exp_t x;
    logic [15:0] o;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      o = observe(x.sel);
      tests++;
      assert (o === x.exp) else begin
        fails++;
        $error("FAIL %s observed=%0h expected=%0h", x.tag, o, x.exp);
      end
    end
  endtask

  task automatic press(input logic [3:0] c, input logic e);
    push("err", 1, {15'h0, e});
    @(negedge clk); key_valid = 1'b1; key_code = c;
    @(negedge clk); drain();
    key_valid = 1'b0;
  endtask

  task automatic all_zero(input string tag);
    push({tag, "_entry"}, 0, 16'h0);
    push({tag, "_err"}, 1, 16'h0);
    push({tag, "_valid"}, 2, 16'h0);
    push({tag, "_ops"}, 3, 16'h0);
    push({tag, "_idx"}, 4, 16'h0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    all_zero("reset");
    drain();
    rst = 1'b0;
    // 127 then -128
    press(4'd1, 0); press(4'd2, 0);
    push("e127", 0, 16'h7F); press(4'd7, 0);
    push("c0_entry", 0, 16'h0); push("c0_idx", 4, 16'd1); press(4'hC, 0);
    press(4'hB, 0); press(4'd1, 0);
    push("neg12", 0, 16'hF4); press(4'd2, 0);
    push("neg128", 0, 16'h80); press(4'd8, 0);
    push("c1_valid", 2, 16'd1); push("c1_ops", 3, 16'h807F); push("c1_idx", 4, 16'd1); press(4'hC, 0);
    repeat (10) @(negedge clk);
    push("hold_valid", 2, 16'd1); push("hold_ops", 3, 16'h807F); drain();
    push("ho_digit_entry", 0, 16'h0); push("ho_digit_ops", 3, 16'h807F); press(4'd5, 0);
    press(4'hB, 0);
    press(4'hC, 0);
    push("ho_code_d_valid", 2, 16'd1); press(4'hD, 1);
    ops_ready = 1'b1;
    @(negedge clk);
    ops_ready = 1'b0;
    push("ack_valid", 2, 16'd0); push("ack_idx", 4, 16'd0); push("ack_ops_kept", 3, 16'h807F); drain();
    // overflow digit
    press(4'd2, 0);
    push("e25", 0, 16'h19); press(4'd5, 0);
`ifdef OPERAND_ENTRY_SAT_EN
    push("ovf_sat", 0, 16'h7F); press(4'd6, 1);
    @(negedge clk); push("err_drop", 1, 16'h0); drain();
    push("sat_neg", 0, 16'h81); press(4'hB, 0);
    push("sat_full", 0, 16'h81); press(4'd1, 1);
`else
    push("ovf_keep", 0, 16'h19); press(4'd6, 1);
    @(negedge clk); push("err_drop", 1, 16'h0); drain();
    push("neg25", 0, 16'hE7); press(4'hB, 0);
    push("ovf251", 0, 16'hE7); press(4'd1, 1);
`endif
    push("clr_entry", 0, 16'h0); push("clr_ops", 3, 16'h0); press(4'hA, 0);
    // held key yields one event
    @(negedge clk); key_valid = 1'b1; key_code = 4'd3;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      push("held_entry", 0, 16'h3); push("held_err", 1, 16'h0); drain();
    end
    key_valid = 1'b0;
    push("c3_idx", 4, 16'd1); push("c3_ops", 3, 16'h0003); press(4'hC, 0);
    push("c_empty_idx", 4, 16'd1); press(4'hC, 1);
    press(4'hA, 0);
    // clear mid-entry
    press(4'd5, 0); press(4'hC, 0);
    push("op0_5", 3, 16'h0005); push("e9", 0, 16'h9); press(4'd9, 0);
    all_zero("clear"); press(4'hA, 0);
    // reset during handoff
    press(4'd1, 0); press(4'hC, 0); press(4'd2, 0);
    push("pre_rst_valid", 2, 16'd1); push("pre_rst_ops", 3, 16'h0201); press(4'hC, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); all_zero("midrst"); drain(); rst = 1'b0;
    press(4'd4, 0); press(4'hC, 0); press(4'd7, 0);
    push("post_rst_ops", 3, 16'h0704); push("post_rst_valid", 2, 16'd1); press(4'hC, 0);
    ops_ready = 1'b1;
    all_zero("clr_prio"); press(4'hA, 0);
    ops_ready = 1'b0;
    // sign toggle rejection at -128
    press(4'hB, 0); press(4'd1, 0); press(4'd2, 0); press(4'd8, 0);
    push("tog_rej", 0, 16'h80); press(4'hB, 1);
    press(4'hA, 0);
    // digit count limit
    press(4'd0, 0); press(4'd0, 0); press(4'd1, 0);
    push("max_dig", 0, 16'h1); press(4'd2, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
